// File: rtl/craps_pkg.sv
// Shared encodings for the craps round controller and its roll classifier.
package craps_pkg;

    typedef enum logic [1:0] {
        ST_COME_OUT = 2'd0,
        ST_POINT    = 2'd1,
        ST_WIN      = 2'd2,
        ST_LOSE     = 2'd3
    } state_t;

    localparam int unsigned SUM_TWO    = 2;
    localparam int unsigned SUM_THREE  = 3;
    localparam int unsigned SUM_SEVEN  = 7;
    localparam int unsigned SUM_ELEVEN = 11;
    localparam int unsigned SUM_TWELVE = 12;

endpackage

// File: rtl/craps_roll_classify.sv
// Combinational roll decode: sum, face legality and natural/craps/seven flags.
module craps_roll_classify
    import craps_pkg::*;
#(
    parameter int DIE_W    = 3,
    parameter int MAX_FACE = 6
) (
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    output logic [DIE_W:0]   sum,
    output logic             legal,
    output logic             is_seven,
    output logic             is_natural,
    output logic             is_craps
);

    localparam logic [DIE_W-1:0] FACE_MAX = DIE_W'(MAX_FACE);
    localparam logic [DIE_W:0]   S2  = (DIE_W+1)'(SUM_TWO);
    localparam logic [DIE_W:0]   S3  = (DIE_W+1)'(SUM_THREE);
    localparam logic [DIE_W:0]   S7  = (DIE_W+1)'(SUM_SEVEN);
    localparam logic [DIE_W:0]   S11 = (DIE_W+1)'(SUM_ELEVEN);
    localparam logic [DIE_W:0]   S12 = (DIE_W+1)'(SUM_TWELVE);

    logic a_ok;
    logic b_ok;

    assign sum = {1'b0, die_a} + {1'b0, die_b};

    assign a_ok  = (die_a != '0) && (die_a <= FACE_MAX);
    assign b_ok  = (die_b != '0) && (die_b <= FACE_MAX);
    assign legal = a_ok && b_ok;

    assign is_seven   = (sum == S7);
    assign is_natural = (sum == S7) || (sum == S11);
    assign is_craps   = (sum == S2) || (sum == S3) || (sum == S12);

endmodule

// File: rtl/craps_round_ctrl.sv
// Pass-line round controller: accepts rolls, tracks the point, keeps tallies.
module craps_round_ctrl
    import craps_pkg::*;
#(
    parameter int DIE_W    = 3,
    parameter int MAX_FACE = 6,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clock_en,
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    input  logic             roll_valid,
    output logic             roll_ready,
    input  logic             new_game,
    input  logic             clear_stats,
    output logic             D7,
    output logic             D711,
    output logic             D2312,
    output logic [DIE_W:0]   point,
    output logic [1:0]       state,
    output logic             win_pulse,
    output logic             lose_pulse,
    output logic             roll_err,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses
);

    state_t           st_q;
    state_t           st_nxt;
    logic [DIE_W:0]   point_nxt;
    logic [DIE_W:0]   sum;
    logic             legal;
    logic             is_seven;
    logic             is_natural;
    logic             is_craps;
    logic             accept;
    logic             good_roll;
    logic             round_over;
    logic             enter_win;
    logic             enter_lose;

    craps_roll_classify #(
        .DIE_W   (DIE_W),
        .MAX_FACE(MAX_FACE)
    ) u_classify (
        .die_a     (die_a),
        .die_b     (die_b),
        .sum       (sum),
        .legal     (legal),
        .is_seven  (is_seven),
        .is_natural(is_natural),
        .is_craps  (is_craps)
    );

    assign round_over = (st_q == ST_WIN) || (st_q == ST_LOSE);
    assign roll_ready = clock_en && !round_over;
    assign accept     = roll_valid && roll_ready;
    assign good_roll  = accept && legal;
    assign state      = st_q;

    always_comb begin
        st_nxt    = st_q;
        point_nxt = point;
        case (st_q)
            ST_COME_OUT: begin
                if (good_roll) begin
                    if (is_natural) begin
                        st_nxt = ST_WIN;
                    end else if (is_craps) begin
                        st_nxt = ST_LOSE;
                    end else begin
                        st_nxt    = ST_POINT;
                        point_nxt = sum;
                    end
                end
            end
            ST_POINT: begin
                if (good_roll) begin
                    if (sum == point) begin
                        st_nxt = ST_WIN;
                    end else if (is_seven) begin
                        st_nxt = ST_LOSE;
                    end
                end
            end
            default: begin
                if (new_game) begin
                    st_nxt    = ST_COME_OUT;
                    point_nxt = '0;
                end
            end
        endcase
    end

    assign enter_win  = !round_over && (st_nxt == ST_WIN);
    assign enter_lose = !round_over && (st_nxt == ST_LOSE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= ST_COME_OUT;
            point      <= '0;
            D7         <= 1'b0;
            D711       <= 1'b0;
            D2312      <= 1'b0;
            win_pulse  <= 1'b0;
            lose_pulse <= 1'b0;
            roll_err   <= 1'b0;
            roll_count <= '0;
            wins       <= '0;
            losses     <= '0;
        end else if (!clock_en) begin
            win_pulse  <= 1'b0;
            lose_pulse <= 1'b0;
            roll_err   <= 1'b0;
        end else begin
            st_q       <= st_nxt;
            point      <= point_nxt;
            win_pulse  <= enter_win;
            lose_pulse <= enter_lose;
            roll_err   <= accept && !legal;

            if (good_roll) begin
                D7    <= is_seven;
                D711  <= is_natural;
                D2312 <= is_craps;
                if (roll_count != '1) begin
                    roll_count <= roll_count + 1'b1;
                end
            end

            if (round_over && new_game) begin
                roll_count <= '0;
            end

            // Clearing takes priority over a same-cycle tally increment.
            if (clear_stats) begin
                wins   <= '0;
                losses <= '0;
            end else begin
                if (enter_win && (wins != '1)) begin
                    wins <= wins + 1'b1;
                end
                if (enter_lose && (losses != '1)) begin
                    losses <= losses + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Directed self-checking bench for craps_round_ctrl.
module tb_craps_round_ctrl;

    logic       clock;
    logic       reset_n;
    logic       clock_en;
    logic [2:0] die_a;
    logic [2:0] die_b;
    logic       roll_valid;
    logic       roll_ready;
    logic       new_game;
    logic       clear_stats;
    logic       D7;
    logic       D711;
    logic       D2312;
    logic [3:0] point;
    logic [1:0] state;
    logic       win_pulse;
    logic       lose_pulse;
    logic       roll_err;
    logic [7:0] roll_count;
    logic [7:0] wins;
    logic [7:0] losses;

    int total = 0;
    int bad   = 0;

    craps_round_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clock_en   (clock_en),
        .die_a      (die_a),
        .die_b      (die_b),
        .roll_valid (roll_valid),
        .roll_ready (roll_ready),
        .new_game   (new_game),
        .clear_stats(clear_stats),
        .D7         (D7),
        .D711       (D711),
        .D2312      (D2312),
        .point      (point),
        .state      (state),
        .win_pulse  (win_pulse),
        .lose_pulse (lose_pulse),
        .roll_err   (roll_err),
        .roll_count (roll_count),
        .wins       (wins),
        .losses     (losses)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic roll(input logic [2:0] a, input logic [2:0] b);
        die_a      = a;
        die_b      = b;
        roll_valid = 1'b1;
        tick();
        roll_valid = 1'b0;
    endtask

    task automatic start_new();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        clock_en    = 1'b1;
        die_a       = '0;
        die_b       = '0;
        roll_valid  = 1'b0;
        new_game    = 1'b0;
        clear_stats = 1'b0;
        #12;
        check("rst_state", 32'(state), 0);
        check("rst_point", 32'(point), 0);
        check("rst_flags", 32'({D7, D711, D2312}), 0);
        check("rst_pulses", 32'({win_pulse, lose_pulse, roll_err}), 0);
        check("rst_count", 32'(roll_count), 0);
        check("rst_tallies", 32'({wins, losses}), 0);
        check("rst_ready", 32'(roll_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;

        roll(3'd3, 3'd4);
        check("r34_flags", 32'({D7, D711, D2312}), 32'b110);
        check("r34_state", 32'(state), 2);
        check("r34_winp", 32'(win_pulse), 1);
        check("r34_wins", 32'(wins), 1);
        check("r34_ready", 32'(roll_ready), 0);
        check("r34_cnt", 32'(roll_count), 1);
        tick();
        check("r34_winp_drop", 32'(win_pulse), 0);
        check("r34_wins_hold", 32'(wins), 1);

        start_new();
        check("ng1_state", 32'(state), 0);
        check("ng1_cnt", 32'(roll_count), 0);
        check("ng1_flags_hold", 32'({D7, D711, D2312}), 32'b110);
        roll(3'd1, 3'd1);
        check("r11_flags", 32'({D7, D711, D2312}), 32'b001);
        check("r11_state", 32'(state), 3);
        check("r11_losep", 32'(lose_pulse), 1);
        check("r11_losses", 32'(losses), 1);
        start_new();
        check("ng2_state", 32'(state), 0);
        check("ng2_point", 32'(point), 0);
        check("ng2_cnt", 32'(roll_count), 0);

        roll(3'd2, 3'd2);
        check("r22_state", 32'(state), 1);
        check("r22_point", 32'(point), 4);
        check("r22_flags", 32'({D7, D711, D2312}), 0);
        new_game = 1'b1;
        roll(3'd5, 3'd5);
        new_game = 1'b0;
        check("r55_state", 32'(state), 1);
        check("r55_cnt", 32'(roll_count), 2);
        roll(3'd1, 3'd3);
        check("r13_state", 32'(state), 2);
        check("r13_wins", 32'(wins), 2);
        check("r13_winp", 32'(win_pulse), 1);
        start_new();

        roll(3'd4, 3'd4);
        check("r44_point", 32'(point), 8);
        check("r44_state", 32'(state), 1);
        clock_en   = 1'b0;
        die_a      = 3'd4;
        die_b      = 3'd4;
        roll_valid = 1'b1;
        #1;
        check("ce0_ready", 32'(roll_ready), 0);
        tick();
        tick();
        roll_valid = 1'b0;
        check("ce0_state", 32'(state), 1);
        check("ce0_cnt", 32'(roll_count), 1);
        check("ce0_wins", 32'(wins), 2);
        clock_en = 1'b1;

        roll(3'd0, 3'd3);
        check("r03_err", 32'(roll_err), 1);
        check("r03_state", 32'(state), 1);
        check("r03_point", 32'(point), 8);
        check("r03_cnt", 32'(roll_count), 1);
        tick();
        check("r03_err_drop", 32'(roll_err), 0);
        roll(3'd7, 3'd2);
        check("r72_err", 32'(roll_err), 1);
        check("r72_state_pt", 32'({state, point}), 32'h18);
        check("r72_flags", 32'({D7, D711, D2312}), 0);

        roll(3'd6, 3'd1);
        check("r61_state", 32'(state), 3);
        check("r61_flags", 32'({D7, D711, D2312}), 32'b110);
        check("r61_losep", 32'(lose_pulse), 1);
        check("r61_losses", 32'(losses), 2);
        check("r61_point", 32'(point), 8);

        die_a = 3'd3;
        die_b = 3'd4;
        roll_valid = 1'b1;
        start_new();
        roll_valid = 1'b0;
        check("ngrv_state", 32'(state), 0);
        check("ngrv_cnt", 32'(roll_count), 0);
        check("ngrv_wins", 32'(wins), 2);

        clear_stats = 1'b1;
        roll(3'd5, 3'd6);
        clear_stats = 1'b0;
        check("clr_state", 32'(state), 2);
        check("clr_winp", 32'(win_pulse), 1);
        check("clr_tallies", 32'({wins, losses}), 0);

        for (int i = 0; i < 255; i++) begin
            start_new();
            roll(3'd3, 3'd4);
        end
        check("sat_wins_255", 32'(wins), 255);
        start_new();
        roll(3'd6, 3'd5);
        check("sat_winp", 32'(win_pulse), 1);
        check("sat_wins_hold", 32'(wins), 255);

        start_new();
        roll(3'd2, 3'd3);
        check("pre_rst_point", 32'(point), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_point", 32'(point), 0);
        check("arst_flags", 32'({D7, D711, D2312}), 0);
        check("arst_pulses", 32'({win_pulse, lose_pulse, roll_err}), 0);
        check("arst_cnts", 32'({roll_count, wins, losses}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
